// File: rtl/ifu.sv
// Instruction fetch unit: issues one read at a time on the instruction bus and buffers the result for decode.
// Optional macro IFU_PERF_CNT_EN enables the fetch/stall performance counters.
module ifu (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        inst_ar_valid,
    input  logic        inst_ar_ready,
    output logic [31:0] inst_araddr,
    input  logic        inst_r_valid,
    output logic        inst_r_ready,
    input  logic [31:0] inst_r_data,
    input  logic [1:0]  inst_r_resp,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_fault,
    input  logic        id_ready,
    output logic        if_id_ready,
    output logic        if_idle,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_discard;
    logic        r_ar_valid;
    logic        r_r_ready;
    logic        r_idle;
    logic [31:0] r_araddr;
    logic        r_pkt_valid;
    logic [31:0] r_pkt_pc;
    logic [31:0] r_pkt_inst;
    logic        r_pkt_fault;

    logic        w_misaligned;
    logic        w_load_pc;
    logic        w_fault_pkt;
    logic        w_load_data;
    logic        w_clr_valid;
    logic        w_set_discard;
    logic        w_clr_discard;
    logic        w_handoff;
    logic        w_rsp_err;

    assign w_misaligned = (fetch_pc[1:0] != 2'b00);
    assign w_rsp_err    = (inst_r_resp != 2'b00);
    assign w_handoff    = r_pkt_valid & id_ready & ~flush;

    always_comb begin
        w_next        = r_state;
        w_load_pc     = 1'b0;
        w_fault_pkt   = 1'b0;
        w_load_data   = 1'b0;
        w_clr_valid   = 1'b0;
        w_set_discard = 1'b0;
        w_clr_discard = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req && !flush) begin
                    w_load_pc = 1'b1;
                    if (w_misaligned) begin
                        w_fault_pkt = 1'b1;
                        w_next      = HOLD;
                    end else begin
                        w_next = ADDR;
                    end
                end
            end
            ADDR: begin
                // A redirect cannot retract the request; remember to drop its response.
                if (flush)
                    w_set_discard = 1'b1;
                if (inst_ar_ready)
                    w_next = DATA;
            end
            DATA: begin
                if (inst_r_valid) begin
                    w_clr_discard = 1'b1;
                    if (r_discard || flush) begin
                        w_next = IDLE;
                    end else begin
                        w_load_data = 1'b1;
                        w_next      = HOLD;
                    end
                end else if (flush) begin
                    w_set_discard = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_clr_valid = 1'b1;
                    w_next      = IDLE;
                end else if (id_ready) begin
                    w_clr_valid = 1'b1;
                    if (fetch_req) begin
                        w_load_pc = 1'b1;
                        if (w_misaligned) begin
                            w_fault_pkt = 1'b1;
                            w_next      = HOLD;
                        end else begin
                            w_next = ADDR;
                        end
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Bus handshake outputs and idle flag are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_idle     <= 1'b1;
            r_discard  <= 1'b0;
            r_araddr   <= '0;
        end else begin
            r_ar_valid <= (w_next == ADDR);
            r_r_ready  <= (w_next == DATA);
            r_idle     <= (w_next == IDLE);
            if (w_clr_discard)
                r_discard <= 1'b0;
            else if (w_set_discard)
                r_discard <= 1'b1;
            if (w_load_pc && !w_misaligned)
                r_araddr <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_valid <= 1'b0;
            r_pkt_pc    <= '0;
            r_pkt_inst  <= '0;
            r_pkt_fault <= 1'b0;
        end else if (w_fault_pkt) begin
            r_pkt_valid <= 1'b1;
            r_pkt_pc    <= fetch_pc;
            r_pkt_inst  <= NOP_INST;
            r_pkt_fault <= 1'b1;
        end else if (w_load_data) begin
            r_pkt_valid <= 1'b1;
            r_pkt_pc    <= r_araddr;
            r_pkt_inst  <= w_rsp_err ? NOP_INST : inst_r_data;
            r_pkt_fault <= w_rsp_err;
        end else if (w_clr_valid) begin
            r_pkt_valid <= 1'b0;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_handoff)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (r_pkt_valid && !id_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

    assign inst_ar_valid = r_ar_valid;
    assign inst_araddr   = r_araddr;
    assign inst_r_ready  = r_r_ready;
    assign if_id_valid   = r_pkt_valid;
    assign if_id_pc      = r_pkt_pc;
    assign if_id_inst    = r_pkt_inst;
    assign if_id_fault   = r_pkt_fault;
    assign if_id_ready   = w_handoff;
    assign if_idle       = r_idle;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run against a transaction-level model.
// Honours IFU_PERF_CNT_EN to choose the expected counter values.
module tb_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        inst_ar_valid;
    logic        inst_ar_ready = 1'b0;
    logic [31:0] inst_araddr;
    logic        inst_r_valid = 1'b0;
    logic        inst_r_ready;
    logic [31:0] inst_r_data = '0;
    logic [1:0]  inst_r_resp = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_fault;
    logic        id_ready = 1'b0;
    logic        if_id_ready;
    logic        if_idle;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int total = 0;
    int bad = 0;

    ifu dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
        .inst_ar_valid(inst_ar_valid), .inst_ar_ready(inst_ar_ready), .inst_araddr(inst_araddr),
        .inst_r_valid(inst_r_valid), .inst_r_ready(inst_r_ready), .inst_r_data(inst_r_data),
        .inst_r_resp(inst_r_resp), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_inst(if_id_inst), .if_id_fault(if_id_fault), .id_ready(id_ready),
        .if_id_ready(if_id_ready), .if_idle(if_idle),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0; inst_ar_ready = 1'b0;
        inst_r_valid = 1'b0; inst_r_data = '0; inst_r_resp = '0; id_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h0000_4000; inst_ar_ready = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({inst_ar_valid, inst_araddr, inst_r_ready, if_id_valid, if_id_pc, if_id_inst, if_id_fault, if_idle}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_values: ar_v=%b addr=%h r_rdy=%b v=%b pc=%h inst=%h f=%b idle=%b, want all 0 with idle=1",
                     inst_ar_valid, inst_araddr, inst_r_ready, if_id_valid, if_id_pc, if_id_inst, if_id_fault, if_idle);
        end
        total++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
            bad++;
            $display("FAIL reset_counters: fetch=%0d stall=%0d, want 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        inst_r_valid = 1'b1; inst_r_data = 32'hCAFE_F00D; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({if_id_valid, inst_r_ready, if_idle} !== 3'b001) begin
                bad++;
                $display("FAIL late_resp_ignored: valid=%b r_ready=%b idle=%b, want 0 0 1",
                         if_id_valid, inst_r_ready, if_idle);
            end
        end
        clear_inputs();
    endtask

    task automatic test_basic_latency();
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h8000_0000; inst_ar_ready = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        total++;
        if ({inst_ar_valid, inst_araddr, if_id_valid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            bad++;
            $display("FAIL basic_ar_cycle1: ar_v=%b addr=%h valid=%b, want 1 80000000 0",
                     inst_ar_valid, inst_araddr, if_id_valid);
        end
        inst_r_valid = 1'b1; inst_r_data = 32'h0010_0093; inst_r_resp = 2'b00;
        @(negedge clk);
        total++;
        if ({inst_ar_valid, inst_r_ready, if_id_valid} !== 3'b010) begin
            bad++;
            $display("FAIL basic_data_cycle2: ar_v=%b r_ready=%b valid=%b, want 0 1 0",
                     inst_ar_valid, inst_r_ready, if_id_valid);
        end
        @(negedge clk);
        inst_r_valid = 1'b0;
        total++;
        if ({if_id_valid, if_id_pc, if_id_inst, if_id_fault, inst_r_ready}
            !== {1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_packet_cycle3: v=%b pc=%h inst=%h f=%b r_ready=%b, want 1 80000000 00100093 0 0",
                     if_id_valid, if_id_pc, if_id_inst, if_id_fault, inst_r_ready);
        end
        id_ready = 1'b1;
        #1;
        total++;
        if (if_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_handoff: if_id_ready=%b, want 1", if_id_ready);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_idle} !== 2'b01) begin
            bad++;
            $display("FAIL basic_back_idle: valid=%b idle=%b, want 0 1", if_id_valid, if_idle);
        end
        clear_inputs();
    endtask

    task automatic test_ar_stall();
        int hs;
        do_reset();
        hs = 0;
        fetch_req = 1'b1; fetch_pc = 32'h0000_1000; inst_ar_ready = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0; fetch_pc = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({inst_ar_valid, inst_araddr} !== {1'b1, 32'h0000_1000}) begin
                bad++;
                $display("FAIL ar_stall_stable: cycle %0d ar_v=%b addr=%h, want 1 00001000", i, inst_ar_valid, inst_araddr);
            end
            @(negedge clk);
        end
        inst_ar_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (inst_ar_valid && inst_ar_ready) hs++;
            @(negedge clk);
        end
        total++;
        if (hs !== 1 || inst_r_ready !== 1'b1) begin
            bad++;
            $display("FAIL ar_single_handshake: handshakes=%0d r_ready=%b, want 1 1", hs, inst_r_ready);
        end
        inst_ar_ready = 1'b0;
        inst_r_valid = 1'b1; inst_r_data = 32'h1234_5678;
        @(negedge clk);
        inst_r_valid = 1'b0;
        total++;
        if ({if_id_valid, if_id_pc, if_id_inst} !== {1'b1, 32'h0000_1000, 32'h1234_5678}) begin
            bad++;
            $display("FAIL ar_stall_packet: v=%b pc=%h inst=%h, want 1 00001000 12345678", if_id_valid, if_id_pc, if_id_inst);
        end
        clear_inputs();
    endtask

    task automatic test_flush_data();
        int seen;
        do_reset();
        seen = 0;
        fetch_req = 1'b1; fetch_pc = 32'h0000_2000; inst_ar_ready = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        inst_ar_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen += int'(if_id_valid);
        @(negedge clk);
        seen += int'(if_id_valid);
        inst_r_valid = 1'b1; inst_r_data = 32'hDEAD_BEEF; id_ready = 1'b1;
        @(negedge clk);
        inst_r_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(if_id_valid);
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_data_dropped: valid cycles=%0d, want 0", seen);
        end
        total++;
        if ({if_idle, inst_r_ready, inst_ar_valid} !== 3'b100) begin
            bad++;
            $display("FAIL flush_data_idle: idle=%b r_ready=%b ar_v=%b, want 1 0 0", if_idle, inst_r_ready, inst_ar_valid);
        end
        clear_inputs();
    endtask

    task automatic test_misaligned();
        int arv;
        do_reset();
        arv = 0;
        fetch_req = 1'b1; fetch_pc = 32'h8000_0002;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            arv += int'(inst_ar_valid);
            total++;
            if ({if_id_valid, if_id_pc, if_id_inst, if_id_fault} !== {1'b1, 32'h8000_0002, NOP, 1'b1}) begin
                bad++;
                $display("FAIL misaligned_packet: v=%b pc=%h inst=%h f=%b, want 1 80000002 00000013 1",
                         if_id_valid, if_id_pc, if_id_inst, if_id_fault);
            end
            @(negedge clk);
        end
        total++;
        if (arv !== 0) begin
            bad++;
            $display("FAIL misaligned_no_bus: ar_valid cycles=%0d, want 0", arv);
        end
        clear_inputs();
    endtask

    task automatic test_resp_fault_stall();
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h0000_3000; inst_ar_ready = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        inst_r_valid = 1'b1; inst_r_data = 32'hAAAA_5555; inst_r_resp = 2'b10;
        @(negedge clk);
        @(negedge clk);
        inst_r_valid = 1'b0; inst_r_resp = 2'b00;
        total++;
        if ({if_id_valid, if_id_inst, if_id_fault} !== {1'b1, NOP, 1'b1}) begin
            bad++;
            $display("FAIL resp_fault_packet: v=%b inst=%h f=%b, want 1 00000013 1", if_id_valid, if_id_inst, if_id_fault);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        total++;
`ifdef IFU_PERF_CNT_EN
        if ({perf_stall_cnt, perf_fetch_cnt} !== {32'd5, 32'd1}) begin
`else
        if ({perf_stall_cnt, perf_fetch_cnt} !== {32'd0, 32'd0}) begin
`endif
            bad++;
            $display("FAIL stall_counter: stall=%0d fetch=%0d, want counters per build", perf_stall_cnt, perf_fetch_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_hold_flush();
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h0000_5004; inst_ar_ready = 1'b1;
        @(negedge clk);
        inst_r_valid = 1'b1; inst_r_data = 32'h0000_0000;
        fetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        inst_r_valid = 1'b0;
        id_ready = 1'b1; flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h0000_6000;
        #1;
        total++;
        if (if_id_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_flush_no_handoff: if_id_ready=%b, want 0", if_id_ready);
        end
        @(negedge clk);
        total++;
        if ({if_id_valid, if_idle, inst_ar_valid} !== 3'b010) begin
            bad++;
            $display("FAIL hold_flush_idle: valid=%b idle=%b ar_v=%b, want 0 1 0", if_id_valid, if_idle, inst_ar_valid);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_req = 1'b1; fetch_pc = 32'h0000_7000; inst_ar_ready = 1'b1;
        @(negedge clk);
        inst_r_valid = 1'b1; inst_r_data = 32'h0000_1111;
        @(negedge clk);
        @(negedge clk);
        inst_r_valid = 1'b0;
        id_ready = 1'b1; fetch_pc = 32'h0000_7004;
        #1;
        total++;
        if (if_id_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_handoff: if_id_ready=%b, want 1", if_id_ready);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        total++;
        if ({inst_ar_valid, inst_araddr, if_id_valid} !== {1'b1, 32'h0000_7004, 1'b0}) begin
            bad++;
            $display("FAIL b2b_next_addr: ar_v=%b addr=%h valid=%b, want 1 00007004 0", inst_ar_valid, inst_araddr, if_id_valid);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit pend, outs, killed, pv, pf, idle, acc, o_pend, o_outs, o_pv;
        logic [31:0] paddr, ppc, pinst, pc_in;
        int unsigned nfetch, nstall;
        do_reset();
        pend = 0; outs = 0; killed = 0; pv = 0; pf = 0;
        paddr = '0; ppc = '0; pinst = '0; nfetch = 0; nstall = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle = !pend && !outs && !pv;
            total++;
            if ({inst_ar_valid, inst_r_ready, if_id_valid, if_idle} !== {pend, outs, pv, idle}) begin
                bad++;
                $display("FAIL rnd_status c=%0d: ar_v=%b r_rdy=%b v=%b idle=%b, want %b %b %b %b", c,
                         inst_ar_valid, inst_r_ready, if_id_valid, if_idle, pend, outs, pv, idle);
            end
            if (pend) begin
                total++;
                if (inst_araddr !== paddr) begin
                    bad++;
                    $display("FAIL rnd_araddr c=%0d: addr=%h, want %h", c, inst_araddr, paddr);
                end
            end
            if (pv) begin
                total++;
                if ({if_id_pc, if_id_inst, if_id_fault} !== {ppc, pinst, pf}) begin
                    bad++;
                    $display("FAIL rnd_packet c=%0d: pc=%h inst=%h f=%b, want %h %h %b", c,
                             if_id_pc, if_id_inst, if_id_fault, ppc, pinst, pf);
                end
            end
            fetch_req = ($urandom_range(0, 3) != 0);
            pc_in = $urandom;
            if ($urandom_range(0, 7) != 0) pc_in[1:0] = 2'b00;
            fetch_pc = pc_in;
            flush = ($urandom_range(0, 9) == 0);
            id_ready = $urandom_range(0, 1) != 0;
            inst_ar_ready = $urandom_range(0, 1) != 0;
            inst_r_valid = outs && ($urandom_range(0, 1) != 0);
            inst_r_data = $urandom;
            inst_r_resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            #1;
            total++;
            if (if_id_ready !== (pv && id_ready && !flush)) begin
                bad++;
                $display("FAIL rnd_if_id_ready c=%0d: got %b, want %b", c, if_id_ready, pv && id_ready && !flush);
            end
            acc = 0;
            o_pend = pend; o_outs = outs; o_pv = pv;
            if (idle && fetch_req && !flush) acc = 1;
            if (o_pend) begin
                if (flush) killed = 1;
                if (inst_ar_ready) begin pend = 0; outs = 1; end
            end
            if (o_outs) begin
                if (inst_r_valid) begin
                    outs = 0;
                    if (!killed && !flush) begin
                        pv = 1; ppc = paddr; pf = (inst_r_resp != 2'b00);
                        pinst = pf ? NOP : inst_r_data;
                    end
                    killed = 0;
                end else if (flush) begin
                    killed = 1;
                end
            end
            if (o_pv) begin
                if (!id_ready) nstall++;
                if (flush) pv = 0;
                else if (id_ready) begin
                    pv = 0; nfetch++;
                    if (fetch_req) acc = 1;
                end
            end
            if (acc) begin
                if (pc_in[1:0] != 2'b00) begin
                    pv = 1; ppc = pc_in; pinst = NOP; pf = 1;
                end else begin
                    pend = 1; paddr = pc_in;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        total++;
`ifdef IFU_PERF_CNT_EN
        if ({perf_fetch_cnt, perf_stall_cnt} !== {nfetch, nstall}) begin
            bad++;
            $display("FAIL rnd_counters: fetch=%0d stall=%0d, want %0d %0d", perf_fetch_cnt, perf_stall_cnt, nfetch, nstall);
        end
`else
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
            bad++;
            $display("FAIL rnd_counters: fetch=%0d stall=%0d, want 0 0 (model %0d %0d)",
                     perf_fetch_cnt, perf_stall_cnt, nfetch, nstall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_ar_stall();
        test_flush_data();
        test_misaligned();
        test_resp_fault_stall();
        test_hold_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
